// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler that time-shares one external registered datapath
// (e <= x3|f, f <= x1&x2) among N_REQ requesters, one transaction at a time.
module pipe_rr_sched #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               dp_x1,
  output logic               dp_x2,
  output logic               dp_x3,
  input  logic               dp_e,
  input  logic               dp_f,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_e,
  output logic               rsp_f
);

  localparam int              CNTW     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LAT - 1);
  localparam logic [IDW:0]    NREQ_W   = (IDW + 1)'(N_REQ);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RSP} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [CNTW-1:0]  cnt_q;
  logic [IDW-1:0]   cur_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic [2:0]       dpx_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_e_q;
  logic             rsp_f_q;

  logic [N_REQ-1:0] rot_req;
  logic             sel_vld;
  logic [IDW:0]     sel_sum;
  logic [IDW-1:0]   sel_id;
  logic [2:0]       sel_op;
  logic [N_REQ-1:0] sel_gnt;

  // Rotate requests so bit 0 is the pointer position; the first set bit wins.
  always_comb begin
    rot_req = N_REQ'({req, req} >> ptr_q);
    sel_vld = 1'b0;
    sel_sum = {1'b0, ptr_q};
    for (int k = 0; k < N_REQ; k++) begin
      if (!sel_vld && rot_req[k]) begin
        sel_vld = 1'b1;
        sel_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
      end
    end
    if (sel_sum >= NREQ_W) begin
      sel_sum = sel_sum - NREQ_W;
    end
    sel_id  = sel_sum[IDW-1:0];
    sel_op  = '0;
    sel_gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == sel_id) begin
        sel_op     = req_data[3*k +: 3];
        sel_gnt[k] = 1'b1;
      end
    end
  end

  assign ptr_d = (cur_q == ID_LAST) ? '0 : cur_q + 1'b1;

  // dpx_q doubles as the latched operand: loaded at selection, held through
  // ISSUE and WAIT, cleared on entry to RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      dpx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_e_q     <= 1'b0;
      rsp_f_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            cur_q   <= sel_id;
            gnt_q   <= sel_gnt;
            dpx_q   <= sel_op;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rsp_e_q     <= dp_e;
            rsp_f_q     <= dp_f;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= cur_q;
            dpx_q       <= '0;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign dp_x1     = dpx_q[0];
  assign dp_x2     = dpx_q[1];
  assign dp_x3     = dpx_q[2];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_e     = rsp_e_q;
  assign rsp_f     = rsp_f_q;

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Bench for pipe_rr_sched: directed scenarios plus random rounds against a
// pointer-based round-robin model and a behavioural copy of the shared datapath.
module tb_pipe_rr_sched;
  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [3*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           dp_x1, dp_x2, dp_x3;
  logic           dp_e, dp_f;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic           rsp_e, rsp_f;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int mptr     = 0;

  always #5 clk = ~clk;

  // Shared datapath outside the scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_e <= 1'b0;
      dp_f <= 1'b0;
    end else begin
      dp_e <= dp_x3 | dp_f;
      dp_f <= dp_x1 & dp_x2;
    end
  end

  pipe_rr_sched #(.N_REQ(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3),
    .dp_e(dp_e), .dp_f(dp_f), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_e(rsp_e), .rsp_f(rsp_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt, busy, dp_x3, dp_x2, dp_x1, rsp_valid, rsp_id, rsp_e, rsp_f});
  endfunction

  function automatic logic [31:0] dpx();
    return 32'({dp_x3, dp_x2, dp_x1});
  endfunction

  // First requester at or after the pointer, wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] slice_of(input logic [3*N-1:0] d, input int w);
    return 3'(d >> (3 * w));
  endfunction

  // dp_x is zero in the IDLE cycle before ISSUE, so f is 0 when e is loaded:
  // with LAT=1 the captured e is x3 and f is x1&x2.
  function automatic logic [31:0] exp_rsp(input logic [2:0] op);
    return 32'({op[2], op[1] & op[0]});
  endfunction

  task automatic run_txn(input logic [N-1:0] r, input logic [3*N-1:0] d, input string tag);
    int w;
    logic [2:0] op;
    w = pick(r, mptr);
    req = r;
    req_data = d;
    @(negedge clk);
    if (w < 0) begin
      check($sformatf("%s_nognt", tag), 32'(gnt), 32'(0));
      check($sformatf("%s_nobusy", tag), 32'(busy), 32'(0));
      req = '0;
      return;
    end
    op = slice_of(d, w);
    check($sformatf("%s_gnt", tag), 32'(gnt), 32'(1) << w);
    check($sformatf("%s_dpx_issue", tag), dpx(), 32'(op));
    check($sformatf("%s_busy", tag), 32'(busy), 32'(1));
    req = '0;
    mptr = (w + 1) % N;
    @(negedge clk);
    check($sformatf("%s_wait_norsp", tag), 32'({gnt, rsp_valid}), 32'(0));
    check($sformatf("%s_dpx_wait", tag), dpx(), 32'(op));
    @(negedge clk);
    check($sformatf("%s_rsp_valid", tag), 32'({gnt, rsp_valid}), 32'(1));
    check($sformatf("%s_rsp_id", tag), 32'(rsp_id), 32'(w));
    check($sformatf("%s_rsp_ef", tag), 32'({rsp_e, rsp_f}), exp_rsp(op));
    check($sformatf("%s_dpx_rsp", tag), dpx(), 32'(0));
    @(negedge clk);
    check($sformatf("%s_idle", tag), 32'({busy, rsp_valid}), 32'(0));
  endtask

  initial begin
    int ngnt, lastcyc, cur;
    logic [3*N-1:0] d3;
    logic [N-1:0] rr;
    logic [3*N-1:0] rd;

    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    #1;
    check("reset_outputs", all_outs(), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({gnt, busy, rsp_valid}), 32'(0));

    // Single request from requester 1, operand {x3,x2,x1}=011.
    run_txn(4'b0010, 12'b000_000_011_000, "single");

    // Abort mid-WAIT with asynchronous reset.
    req = 4'b0100;
    req_data = 12'b000_111_000_000;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'(4'b0100));
    req = '0;
    @(negedge clk);
    check("abort_wait_dpx", dpx(), 32'(3'b111));
    #1 rst_n = 1'b0;
    #1 check("abort_async_zero", all_outs(), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'({busy, rsp_valid}), 32'(0));
    end

    // All four requesting continuously: order 0,1,2,3,0 every LAT+3 cycles.
    d3 = 12'($urandom);
    req = 4'b1111;
    req_data = d3;
    ngnt = 0;
    lastcyc = 0;
    cur = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      check("all_excl", 32'(gnt != '0 && rsp_valid), 32'(0));
      check("all_onehot", 32'($onehot0(gnt)), 32'(1));
      if (gnt != '0) begin
        check("all_gnt_order", 32'(gnt), 32'(1) << mptr);
        check("all_dpx", dpx(), 32'(slice_of(d3, mptr)));
        if (ngnt > 0) check("all_gap", 32'(cyc - lastcyc), 32'(LAT + 3));
        cur = mptr;
        mptr = (mptr + 1) % N;
        lastcyc = cyc;
        ngnt++;
        if (ngnt == 5) req = '0;
      end
      if (rsp_valid) begin
        check("all_rsp_id", 32'(rsp_id), 32'(cur));
        check("all_rsp_ef", 32'({rsp_e, rsp_f}), exp_rsp(slice_of(d3, cur)));
      end
      if (ngnt == 5 && !busy) break;
    end
    check("all_gnt_count", 32'(ngnt), 32'(5));
    check("all_drained", 32'(busy), 32'(0));

    // Move pointer to 3, then wrap: 3 is served, then 0 rather than 3 again.
    run_txn(4'b0100, 12'($urandom), "to_ptr3");
    run_txn(4'b1001, 12'($urandom), "wrap_first");
    check("wrap_ptr_model", 32'(mptr), 32'(0));
    run_txn(4'b1001, 12'($urandom), "wrap_second");

    // Withdrawn request: req[2] high for one WAIT cycle only.
    req = 4'b0001;
    req_data = 12'($urandom);
    @(negedge clk);
    check("wd_gnt0", 32'(gnt), 32'(4'b0001));
    req = '0;
    mptr = 1;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    check("wd_rsp_id", 32'({rsp_valid, rsp_id}), 32'({1'b1, 2'd0}));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("wd_never_granted", 32'({gnt, busy, rsp_valid}), 32'(0));
    end

    // Operand stability: req_data of the granted requester changes after selection.
    req = 4'b0100;
    req_data = 12'b000_110_000_000;
    @(negedge clk);
    check("stab_gnt", 32'(gnt), 32'(4'b0100));
    check("stab_dpx_issue", dpx(), 32'(3'b110));
    req = '0;
    req_data = 12'b000_001_000_000;
    @(negedge clk);
    req_data = 12'b000_101_000_000;
    check("stab_dpx_wait", dpx(), 32'(3'b110));
    @(negedge clk);
    check("stab_rsp", 32'({rsp_valid, rsp_id, rsp_e, rsp_f}), 32'({1'b1, 2'd2, 1'b1, 1'b0}));
    @(negedge clk);
    check("stab_idle", 32'(busy), 32'(0));
    mptr = 3;

    // Random rounds against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      rr = 4'($urandom_range(0, 15));
      rd = 12'($urandom);
      run_txn(rr, rd, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
